// File: rtl/cpri_tx_gen_mc_pkg.sv
// -----------------------------------------------------------------------------
// cpri_tx_gen_mc_pkg
// Shared types and width helpers for the multi-channel CPRI TX IQ generator.
//   ch_width()   : channel tag width, at least 1 bit even for a single channel
//   slot_width() : packet slot pointer width for a power-of-two slot count
//   arb_state_e  : readout arbiter state
// -----------------------------------------------------------------------------
package cpri_tx_gen_mc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } arb_state_e;

  function automatic int ch_width(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int slot_width(input int num_buf);
    return $clog2(num_buf);
  endfunction

endpackage

// File: rtl/cpri_tx_gen_mc_if.sv
// -----------------------------------------------------------------------------
// cpri_tx_gen_mc_if
// Bundles the packet write port (from the PUSCH DR packer), the IQ TX stream
// (towards the CPRI IQ TX interface) and the status flags.
//   slave  : the generator side (consumes i_*, drives o_*)
//   master : the environment side (drives i_*, consumes o_*)
// Signals:
//   i_cpri_wen/wch/waddr/wdata/wlast : packet word write, wlast commits
//   i_iq_tx_enable                   : permission to start a new burst
//   o_iq_tx_valid/data/ch/sop/eop    : payload stream
//   o_ch_rdy                         : per-channel "has committed packet"
//   o_wr_ovf                         : one-cycle pulse, packet dropped
// -----------------------------------------------------------------------------
interface cpri_tx_gen_mc_if
  import cpri_tx_gen_mc_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 7,
  parameter int NUM_CH = 4
);
  localparam int CH_W = ch_width(NUM_CH);

  logic              i_cpri_wen;
  logic [CH_W-1:0]   i_cpri_wch;
  logic [ADDR_W-1:0] i_cpri_waddr;
  logic [DATA_W-1:0] i_cpri_wdata;
  logic              i_cpri_wlast;
  logic              i_iq_tx_enable;
  logic              o_iq_tx_valid;
  logic [DATA_W-1:0] o_iq_tx_data;
  logic [CH_W-1:0]   o_iq_tx_ch;
  logic              o_iq_tx_sop;
  logic              o_iq_tx_eop;
  logic [NUM_CH-1:0] o_ch_rdy;
  logic              o_wr_ovf;

  modport slave (
    input  i_cpri_wen, i_cpri_wch, i_cpri_waddr, i_cpri_wdata, i_cpri_wlast,
    input  i_iq_tx_enable,
    output o_iq_tx_valid, o_iq_tx_data, o_iq_tx_ch, o_iq_tx_sop, o_iq_tx_eop,
    output o_ch_rdy, o_wr_ovf
  );

  modport master (
    output i_cpri_wen, i_cpri_wch, i_cpri_waddr, i_cpri_wdata, i_cpri_wlast,
    output i_iq_tx_enable,
    input  o_iq_tx_valid, o_iq_tx_data, o_iq_tx_ch, o_iq_tx_sop, o_iq_tx_eop,
    input  o_ch_rdy, o_wr_ovf
  );

endinterface

// File: rtl/cpri_tx_gen_mc_sdp_ram_sc.sv
// -----------------------------------------------------------------------------
// cpri_tx_gen_mc_sdp_ram_sc
// Single-clock simple dual-port RAM with an RD_LAT-stage registered read path.
// Ports:
//   clk              : clock
//   we_i/waddr_i/wdata_i : write port
//   re_i/raddr_i     : read request, data appears on rdata_o RD_LAT cycles later
//   rdata_o          : read data (not reset, qualified by the caller)
// -----------------------------------------------------------------------------
module cpri_tx_gen_mc_sdp_ram_sc #(
  parameter int DATA_W = 64,
  parameter int AW     = 11,
  parameter int DEPTH  = 2048,
  parameter int RD_LAT = 3
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_pq [RD_LAT];

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // stage 0: array read; later stages: output register chain
  always_ff @(posedge clk) begin
    if (re_i) rd_pq[0] <= mem[raddr_i];
    for (int s = 1; s < RD_LAT; s++) rd_pq[s] <= rd_pq[s-1];
  end

  assign rdata_o = rd_pq[RD_LAT-1];

endmodule

// File: rtl/cpri_tx_gen_mc.sv
// -----------------------------------------------------------------------------
// cpri_tx_gen_mc
// Multi-channel CPRI TX IQ generator. Packets are written per channel into
// NUM_BUF slots; committed packets are read out round-robin, skipping HDR_LEN
// header words and streaming PAY_LEN payload words with sop/eop/channel tag.
// Ports:
//   clk : clock
//   rst : synchronous active-high reset
//   bus : cpri_tx_gen_mc_if.slave (write port, IQ TX stream, status flags)
// -----------------------------------------------------------------------------
module cpri_tx_gen_mc
  import cpri_tx_gen_mc_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 7,
  parameter int NUM_CH  = 4,
  parameter int NUM_BUF = 4,
  parameter int HDR_LEN = 3,
  parameter int PAY_LEN = 96,
  parameter int RD_LAT  = 3
) (
  input  logic clk,
  input  logic rst,
  cpri_tx_gen_mc_if.slave bus
);

  localparam int CH_W   = ch_width(NUM_CH);
  localparam int SLOT_W = slot_width(NUM_BUF);
  localparam int CNT_W  = SLOT_W + 1;
  localparam int RAM_AW = CH_W + SLOT_W + ADDR_W;
  localparam int DEPTH  = NUM_CH * NUM_BUF * (2 ** ADDR_W);

  localparam logic [ADDR_W-1:0] FIRST_A  = ADDR_W'(HDR_LEN);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(HDR_LEN + PAY_LEN - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_BUF);

  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];
  logic [SLOT_W-1:0] wr_ptr_q [NUM_CH];
  logic [SLOT_W-1:0] rd_ptr_q [NUM_CH];
  logic [NUM_CH-1:0] ch_rdy_q, ch_rdy_d;
  logic              wr_ovf_q;

  arb_state_e        state_q;
  logic [CH_W-1:0]   grant_q, rr_last_q, rr_pick, rr_idx;
  logic              rr_found;
  logic [ADDR_W-1:0] raddr_q;

  logic wr_full, wr_en, wr_commit, rd_release;

  // A full channel blocks every write, so the slot under readout is never hit.
  assign wr_full    = (cnt_q[bus.i_cpri_wch] == FULL_CNT);
  assign wr_en      = bus.i_cpri_wen && !wr_full;
  assign wr_commit  = wr_en && bus.i_cpri_wlast;
  assign rd_release = (state_q == READ) && (raddr_q == LAST_A);

  // Commit and release on the same channel cancel out.
  always_comb begin
    ch_rdy_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (wr_commit && (bus.i_cpri_wch == CH_W'(c))) cnt_d[c] = cnt_d[c] + CNT_W'(1);
      if (rd_release && (grant_q == CH_W'(c)))       cnt_d[c] = cnt_d[c] - CNT_W'(1);
      ch_rdy_d[c] = (cnt_d[c] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]    <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
      end
      ch_rdy_q <= '0;
      wr_ovf_q <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) cnt_q[c] <= cnt_d[c];
      if (wr_commit)  wr_ptr_q[bus.i_cpri_wch] <= wr_ptr_q[bus.i_cpri_wch] + SLOT_W'(1);
      if (rd_release) rd_ptr_q[grant_q]        <= rd_ptr_q[grant_q] + SLOT_W'(1);
      ch_rdy_q <= ch_rdy_d;
      wr_ovf_q <= bus.i_cpri_wen && bus.i_cpri_wlast && wr_full;
    end
  end

  // Round-robin: first non-empty channel after the last one granted.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = rr_last_q;
    rr_idx   = rr_last_q;
    for (int i = 1; i <= NUM_CH; i++) begin
      rr_idx = CH_W'((int'(rr_last_q) + i) % NUM_CH);
      if (!rr_found && (cnt_q[rr_idx] != '0)) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx;
      end
    end
  end

  // Enable is only looked at in IDLE; a started burst always runs to the end,
  // and the return to IDLE guarantees a one-cycle gap between bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_last_q <= CH_W'(NUM_CH - 1);
      raddr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_iq_tx_enable && rr_found) begin
            state_q   <= READ;
            grant_q   <= rr_pick;
            rr_last_q <= rr_pick;
            raddr_q   <= FIRST_A;
          end
        end
        READ: begin
          raddr_q <= raddr_q + ADDR_W'(1);
          if (raddr_q == LAST_A) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // stage p0: read issue, sideband formed alongside the RAM address
  logic            vld_p0, sop_p0, eop_p0;
  logic [CH_W-1:0] ch_p0;
  logic [RAM_AW-1:0] ram_waddr, ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  assign vld_p0    = (state_q == READ);
  assign sop_p0    = vld_p0 && (raddr_q == FIRST_A);
  assign eop_p0    = rd_release;
  assign ch_p0     = grant_q;
  assign ram_waddr = {bus.i_cpri_wch, wr_ptr_q[bus.i_cpri_wch], bus.i_cpri_waddr};
  assign ram_raddr = {grant_q, rd_ptr_q[grant_q], raddr_q};

  cpri_tx_gen_mc_sdp_ram_sc #(
    .DATA_W (DATA_W),
    .AW     (RAM_AW),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (ram_waddr),
    .wdata_i (bus.i_cpri_wdata),
    .re_i    (vld_p0),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  // stages p1..pRD_LAT: sideband delay line matching the RAM read latency
  logic            vld_pq [RD_LAT];
  logic            sop_pq [RD_LAT];
  logic            eop_pq [RD_LAT];
  logic [CH_W-1:0] ch_pq  [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        vld_pq[s] <= 1'b0;
        sop_pq[s] <= 1'b0;
        eop_pq[s] <= 1'b0;
        ch_pq[s]  <= '0;
      end
    end else begin
      vld_pq[0] <= vld_p0;
      sop_pq[0] <= sop_p0;
      eop_pq[0] <= eop_p0;
      ch_pq[0]  <= ch_p0;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pq[s] <= vld_pq[s-1];
        sop_pq[s] <= sop_pq[s-1];
        eop_pq[s] <= eop_pq[s-1];
        ch_pq[s]  <= ch_pq[s-1];
      end
    end
  end

  // RAM data is not reset; forcing it to zero when idle keeps outputs quiet.
  assign bus.o_iq_tx_valid = vld_pq[RD_LAT-1];
  assign bus.o_iq_tx_data  = vld_pq[RD_LAT-1] ? ram_rdata : '0;
  assign bus.o_iq_tx_ch    = ch_pq[RD_LAT-1];
  assign bus.o_iq_tx_sop   = sop_pq[RD_LAT-1];
  assign bus.o_iq_tx_eop   = eop_pq[RD_LAT-1];
  assign bus.o_ch_rdy      = ch_rdy_q;
  assign bus.o_wr_ovf      = wr_ovf_q;

endmodule

// File: tb/tb_cpri_tx_gen_mc.sv
// -----------------------------------------------------------------------------
// tb_cpri_tx_gen_mc
// Scoreboard bench: stimulus pushes the expected payload beats of every packet
// that must be read out; a negedge monitor pops and compares each valid beat
// and tracks burst contiguity and inter-burst gaps.
// -----------------------------------------------------------------------------
module tb_cpri_tx_gen_mc;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 7;
  localparam int NUM_CH  = 4;
  localparam int NUM_BUF = 2;
  localparam int HDR_LEN = 3;
  localparam int PAY_LEN = 96;
  localparam int RD_LAT  = 3;
  localparam int LAST_A  = HDR_LEN + PAY_LEN - 1;

  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  ch;
    logic        sop;
    logic        eop;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  cpri_tx_gen_mc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) bus ();

  cpri_tx_gen_mc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .NUM_BUF(NUM_BUF),
    .HDR_LEN(HDR_LEN), .PAY_LEN(PAY_LEN), .RD_LAT(RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    n_chk  = 0;
  int    n_pass = 0;
  beat_t exp_q[$];
  int    wl_cyc, sop_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    else n_pass++;
  endtask

  function automatic logic [63:0] mk(input int tag, input int a);
    return {32'(tag), 32'(a)};
  endfunction

  task automatic push_pkt(input int ch, input int tag);
    for (int a = HDR_LEN; a <= LAST_A; a++)
      exp_q.push_back({mk(tag, a), 2'(ch), (a == HDR_LEN), (a == LAST_A)});
  endtask

  // ---------------- monitor ----------------
  bit    in_burst  = 0;
  bit    after_eop = 0;
  beat_t got, want;

  always @(negedge clk) begin
    if (after_eop) chk("gap_after_eop", 64'(bus.o_iq_tx_valid), 64'(0));
    if (in_burst)  chk("contiguous_valid", 64'(bus.o_iq_tx_valid), 64'(1));
    after_eop = 0;
    if (bus.o_iq_tx_valid === 1'b1) begin
      got = {bus.o_iq_tx_data, bus.o_iq_tx_ch, bus.o_iq_tx_sop, bus.o_iq_tx_eop};
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 64'(bus.o_iq_tx_valid), 64'(0));
      end else begin
        want = exp_q.pop_front();
        chk("beat_data", got.d, want.d);
        chk("beat_ch_sop_eop", 64'({got.ch, got.sop, got.eop}), 64'({want.ch, want.sop, want.eop}));
      end
      if (got.sop) in_burst = 1;
      if (got.eop) begin in_burst = 0; after_eop = 1; end
    end
    if (rst === 1'b1) begin in_burst = 0; after_eop = 0; end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wr_word(input int ch, input int a, input logic [63:0] d, input logic last);
    @(posedge clk); #1;
    bus.i_cpri_wen   = 1'b1;
    bus.i_cpri_wch   = 2'(ch);
    bus.i_cpri_waddr = 7'(a);
    bus.i_cpri_wdata = d;
    bus.i_cpri_wlast = last;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.i_cpri_wen   = 1'b0;
    bus.i_cpri_wlast = 1'b0;
  endtask

  task automatic write_pkt(input int ch, input int tag, input logic ovf_exp);
    for (int a = 0; a <= LAST_A; a++) wr_word(ch, a, mk(tag, a), (a == LAST_A));
    wl_cyc = cyc;
    idle_cycle();
    @(negedge clk); chk("wr_ovf_pulse", 64'(bus.o_wr_ovf), 64'(ovf_exp));
    @(negedge clk); chk("wr_ovf_clear", 64'(bus.o_wr_ovf), 64'(0));
  endtask

  task automatic set_en(input logic en);
    @(posedge clk); #1;
    bus.i_iq_tx_enable = en;
  endtask

  task automatic wait_sop(input int ch, input int budget);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_iq_tx_sop === 1'b1 && bus.o_iq_tx_ch == 2'(ch)) begin
        found = 1;
        break;
      end
    end
    sop_cyc = cyc;
    chk("sop_seen", 64'(found), 64'(1));
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && bus.o_iq_tx_valid == 1'b0) break;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic do_reset(input int ncyc);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.i_iq_tx_enable = 1'b0;
    bus.i_cpri_wen     = 1'b0;
    bus.i_cpri_wlast   = 1'b0;
    repeat (ncyc - 1) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_valid", 64'(bus.o_iq_tx_valid), 64'(0));
    chk("rst_sop_eop", 64'({bus.o_iq_tx_sop, bus.o_iq_tx_eop}), 64'(0));
    chk("rst_ch_data", 64'(bus.o_iq_tx_ch) | bus.o_iq_tx_data, 64'(0));
    chk("rst_ch_rdy", 64'(bus.o_ch_rdy), 64'(0));
    chk("rst_wr_ovf", 64'(bus.o_wr_ovf), 64'(0));
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1;
    bus.i_cpri_wen     = 1'b0;
    bus.i_cpri_wch     = '0;
    bus.i_cpri_waddr   = '0;
    bus.i_cpri_wdata   = '0;
    bus.i_cpri_wlast   = 1'b0;
    bus.i_iq_tx_enable = 1'b0;
    do_reset(3);

    // 1: single packet on ch2, enable held high, data = address
    set_en(1'b1);
    push_pkt(2, 0);
    write_pkt(2, 0, 1'b0);
    chk("t1_ch_rdy", 64'(bus.o_ch_rdy), 64'(4'b0100));
    wait_sop(2, 20);
    chk("t1_sop_latency", 64'(sop_cyc - wl_cyc), 64'(5));
    drain(200);
    chk("t1_ch_rdy_empty", 64'(bus.o_ch_rdy), 64'(0));

    // 2: ch0, ch1, ch3 served in round-robin order; new ch0 packet follows
    do_reset(2);
    write_pkt(0, 10, 1'b0);
    write_pkt(1, 11, 1'b0);
    write_pkt(3, 12, 1'b0);
    chk("t2_ch_rdy", 64'(bus.o_ch_rdy), 64'(4'b1011));
    push_pkt(0, 10);
    push_pkt(1, 11);
    push_pkt(3, 12);
    push_pkt(0, 13);
    set_en(1'b1);
    wait_sop(3, 500);
    write_pkt(0, 13, 1'b0);
    drain(400);
    set_en(1'b0);
    chk("t2_ch_rdy_empty", 64'(bus.o_ch_rdy), 64'(0));

    // 4: enable dropped mid-burst; burst completes, nothing new starts
    write_pkt(1, 20, 1'b0);
    write_pkt(2, 21, 1'b0);
    push_pkt(1, 20);
    set_en(1'b1);
    wait_sop(1, 20);
    repeat (9) @(posedge clk);
    set_en(1'b0);
    drain(200);
    repeat (120) @(posedge clk);
    @(negedge clk);
    chk("t4_ch_rdy_pending", 64'(bus.o_ch_rdy), 64'(4'b0100));
    chk("t4_no_burst", 64'(bus.o_iq_tx_valid), 64'(0));
    push_pkt(2, 21);
    set_en(1'b1);
    drain(200);
    set_en(1'b0);

    // 3: third packet to a full ch1 is dropped with an overflow pulse
    write_pkt(1, 30, 1'b0);
    write_pkt(1, 31, 1'b0);
    write_pkt(1, 32, 1'b1);
    chk("t3_ch_rdy", 64'(bus.o_ch_rdy), 64'(4'b0010));
    push_pkt(1, 30);
    push_pkt(1, 31);
    set_en(1'b1);
    drain(400);
    set_en(1'b0);
    chk("t3_ch_rdy_empty", 64'(bus.o_ch_rdy), 64'(0));

    // 5: commit on ch0 in the same cycle its only packet is released
    write_pkt(0, 40, 1'b0);
    for (int a = 0; a < LAST_A; a++) wr_word(0, a, mk(41, a), 1'b0);
    idle_cycle();
    push_pkt(0, 40);
    push_pkt(0, 41);
    set_en(1'b1);
    wait_sop(0, 20);
    repeat (91) @(posedge clk);
    wr_word(0, LAST_A, mk(41, LAST_A), 1'b1);
    @(negedge clk);
    chk("t5_ch_rdy_release", 64'(bus.o_ch_rdy[0]), 64'(1));
    idle_cycle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_ch_rdy_hold", 64'(bus.o_ch_rdy[0]), 64'(1));
    end
    drain(200);
    set_en(1'b0);
    chk("t5_ch_rdy_empty", 64'(bus.o_ch_rdy), 64'(0));

    // 6: one-cycle reset at beat 50 aborts the burst; fresh packet afterwards
    write_pkt(0, 50, 1'b0);
    push_pkt(0, 50);
    set_en(1'b1);
    wait_sop(0, 20);
    repeat (48) @(posedge clk);
    do_reset(1);
    repeat (20) @(negedge clk);
    chk("t6_quiet_after_rst", 64'(bus.o_iq_tx_valid), 64'(0));
    write_pkt(0, 51, 1'b0);
    chk("t6_ch_rdy", 64'(bus.o_ch_rdy), 64'(4'b0001));
    push_pkt(0, 51);
    set_en(1'b1);
    drain(200);
    set_en(1'b0);
    chk("t6_ch_rdy_empty", 64'(bus.o_ch_rdy), 64'(0));

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
